mon_exp_ctrl: RTL and testbench
===============================

// Module: mon_exp_ctrl
// PURPOSE
//  Sequencer that computes X^E in the Montgomery domain by driving one monProduct instance.
//  Host supplies Montgomery-form base, Montgomery one (R mod M), exponent and modulus.
//  Uses left-to-right square-and-multiply: one monProduct call per square and per multiply.
//  Sits between the ECC/RSA top-level scheduler and the shared monProduct datapath.
// PARAMETERS
//  DATA_WIDTH  192  operand/modulus width; must equal the monProduct DATA_WIDTH
//  EXP_WIDTH   192  exponent width; bit index counter is $clog2(EXP_WIDTH) bits
// PORTS
//  clk           in   1           clock, all state updates on rising edge
//  rst           in   1           asynchronous, active-high reset
//  start         in   1           1-cycle request; sampled only in IDLE
//  base_m        in   DATA_WIDTH  base in Montgomery form (x*R mod M), captured on start
//  one_m         in   DATA_WIDTH  R mod M, captured on start
//  exp           in   EXP_WIDTH   exponent E, captured on start
//  mod_m         in   DATA_WIDTH  modulus M, odd, M < 2^(DATA_WIDTH-1), captured on start
//  busy          out  1           high from cycle after accepted start until done pulse
//  done          out  1           1-cycle pulse; result valid in same cycle
//  result        out  DATA_WIDTH  canonical (x^E)*R mod M, held until next accepted start
//  mp_opA        out  DATA_WIDTH  monProduct opA
//  mp_opB        out  DATA_WIDTH  monProduct opB
//  mp_opM        out  DATA_WIDTH  monProduct opM (= captured mod_m)
//  mp_in_valid   out  1           1-cycle launch pulse to monProduct
//  mp_out_data   in   DATA_WIDTH  monProduct result, may be in [0, M] (not fully reduced)
//  mp_out_valid  in   1           monProduct completion pulse
// BEHAVIOUR
//  Reset: state IDLE; busy, done, mp_in_valid = 0; result, mp_opA/B/M, acc, idx = 0.
//  States: IDLE, SCAN, SQR_GO, SQR_WAIT, MUL_GO, MUL_WAIT, FINAL, DONE.
//  IDLE: start=1 -> capture inputs, idx <= EXP_WIDTH-1, go SCAN. start in any other state ignored.
//  SCAN: one exponent bit per cycle, skip leading zeros.
//   exp[idx]=1 -> acc <= base_m; if idx==0 go FINAL else idx <= idx-1, go SQR_GO.
//   exp[idx]=0 and idx==0 (E==0) -> acc <= one_m, go FINAL. else idx <= idx-1.
//  SQR_GO: mp_opA=mp_opB=acc, mp_in_valid=1 for exactly this cycle, go SQR_WAIT.
//  SQR_WAIT: mp_opA/B held stable until mp_out_valid (monProduct samples operands one cycle after launch).
//   On mp_out_valid: acc <= mp_out_data; exp[idx]=1 -> MUL_GO; else idx==0 -> FINAL, else idx--, SQR_GO.
//  MUL_GO: mp_opA=acc, mp_opB=base_m, mp_in_valid=1 one cycle, go MUL_WAIT.
//  MUL_WAIT: on mp_out_valid acc <= mp_out_data; idx==0 -> FINAL, else idx--, SQR_GO.
//  mp_out_valid outside *_WAIT ignored. No timeout: WAIT states hold until mp_out_valid.
//  FINAL: result <= (acc >= M) ? acc-M : acc (single compare/subtract, DATA_WIDTH bits), go DONE.
//  DONE: done=1 one cycle, busy drops same cycle, go IDLE. start accepted again next cycle.
//  Operation count: (bitlen(E)-1) squares + (popcount(E)-1) multiplies; E in {0,1} -> zero calls.
//  Latency: start->done = 1 + scan cycles + sum over calls (1 + monProduct latency) + 2.
//  mp_opM driven from captured mod_m whenever busy; mp_opA/B hold last value when idle.
//  Reset mid-operation: returns to IDLE immediately, pending call abandoned; system must reset monProduct too.
//  Inputs sampled only on accepted start; later changes have no effect on the running operation.
// TESTING  (DATA_WIDTH=8, EXP_WIDTH=8, M=13, R=256, one_m=9, base_m=5 i.e. x=2)
//  E=5 -> exactly 3 mp_in_valid pulses (SQR,SQR,MUL), done with result=2 (32*256 mod 13).
//  E=12 -> 4 calls (SQR,MUL,SQR,SQR), result=9 (2^12 mod 13 = 1).
//  E=0 -> no mp_in_valid, done with result=9; E=1 -> no calls, result=5.
//  Stub monProduct returning M (13) -> FINAL reduces, result=0; mp_opA/B stable over each WAIT.
//  start pulsed while busy and stray mp_out_valid in SQR_GO -> ignored, result unchanged vs clean run.
//  rst asserted during SQR_WAIT -> all outputs 0 next edge, new start after release gives correct result.

Source files
------------

// File: rtl/mon_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer computing X^E in the Montgomery domain
// by issuing one call per square/multiply to a shared monProduct datapath.
module mon_exp_ctrl #(
  parameter int unsigned DATA_WIDTH = 192,
  parameter int unsigned EXP_WIDTH  = 192
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] base_m,
  input  logic [DATA_WIDTH-1:0] one_m,
  input  logic [EXP_WIDTH-1:0]  exp,
  input  logic [DATA_WIDTH-1:0] mod_m,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic [DATA_WIDTH-1:0] mp_opA,
  output logic [DATA_WIDTH-1:0] mp_opB,
  output logic [DATA_WIDTH-1:0] mp_opM,
  output logic                  mp_in_valid,
  input  logic [DATA_WIDTH-1:0] mp_out_data,
  input  logic                  mp_out_valid
);

  localparam int unsigned IdxW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(EXP_WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle, StScan, StSqrGo, StSqrWait, StMulGo, StMulWait, StFinal, StDone
  } state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] base_q, base_d;
  logic [DATA_WIDTH-1:0] one_q, one_d;
  logic [EXP_WIDTH-1:0]  exp_q, exp_d;
  logic [DATA_WIDTH-1:0] mod_q, mod_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [DATA_WIDTH-1:0] opa_q, opa_d;
  logic [DATA_WIDTH-1:0] opb_q, opb_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      acc_q    <= '0;
      base_q   <= '0;
      one_q    <= '0;
      exp_q    <= '0;
      mod_q    <= '0;
      result_q <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      base_q   <= base_d;
      one_q    <= one_d;
      exp_q    <= exp_d;
      mod_q    <= mod_d;
      result_q <= result_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    base_d   = base_q;
    one_d    = one_q;
    exp_d    = exp_q;
    mod_d    = mod_q;
    result_d = result_q;
    opa_d    = opa_q;
    opb_d    = opb_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          base_d  = base_m;
          one_d   = one_m;
          exp_d   = exp;
          mod_d   = mod_m;
          idx_d   = IdxLast;
          state_d = StScan;
        end
      end
      StScan: begin
        if (exp_q[idx_q]) begin
          acc_d = base_q;
          if (idx_q == '0) begin
            state_d = StFinal;
          end else begin
            idx_d   = idx_q - 1'b1;
            state_d = StSqrGo;
          end
        end else if (idx_q == '0) begin
          acc_d   = one_q;
          state_d = StFinal;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      StSqrGo: state_d = StSqrWait;
      StSqrWait: begin
        if (mp_out_valid) begin
          acc_d = mp_out_data;
          if (exp_q[idx_q]) begin
            state_d = StMulGo;
          end else if (idx_q == '0) begin
            state_d = StFinal;
          end else begin
            idx_d   = idx_q - 1'b1;
            state_d = StSqrGo;
          end
        end
      end
      StMulGo: state_d = StMulWait;
      StMulWait: begin
        if (mp_out_valid) begin
          acc_d = mp_out_data;
          if (idx_q == '0) begin
            state_d = StFinal;
          end else begin
            idx_d   = idx_q - 1'b1;
            state_d = StSqrGo;
          end
        end
      end
      StFinal: begin
        // monProduct output lies in [0, M], so one conditional subtract is enough
        result_d = (acc_q >= mod_q) ? (acc_q - mod_q) : acc_q;
        state_d  = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Operands are registered on entry to a launch state and then held through the wait
    if (state_d == StSqrGo) begin
      opa_d = acc_d;
      opb_d = acc_d;
    end else if (state_d == StMulGo) begin
      opa_d = acc_d;
      opb_d = base_q;
    end
  end

  assign busy        = (state_q != StIdle) && (state_q != StDone);
  assign done        = (state_q == StDone);
  assign mp_in_valid = (state_q == StSqrGo) || (state_q == StMulGo);
  assign result      = result_q;
  assign mp_opA      = opa_q;
  assign mp_opB      = opb_q;
  assign mp_opM      = mod_q;

endmodule

// File: tb/tb_mon_exp_ctrl.sv
// Scoreboard bench for mon_exp_ctrl with a behavioural monProduct (M=13, R=256).
module tb_mon_exp_ctrl;

  localparam int DW  = 8;
  localparam int EW  = 8;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] base_m, one_m, mod_m;
  logic [EW-1:0] exp;
  logic          busy, done, mp_in_valid, mp_out_valid;
  logic [DW-1:0] result, mp_opA, mp_opB, mp_opM, mp_out_data;

  int n_vec = 0;
  int n_bad = 0;

  logic [DW-1:0] exp_res_q[$];
  int            exp_calls_q[$];

  bit stub     = 1'b0;
  bit stray_en = 1'b0;

  always #5 clk = ~clk;

  mon_exp_ctrl #(.DATA_WIDTH(DW), .EXP_WIDTH(EW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_m      (base_m),
    .one_m       (one_m),
    .exp         (exp),
    .mod_m       (mod_m),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .mp_opA      (mp_opA),
    .mp_opB      (mp_opB),
    .mp_opM      (mp_opM),
    .mp_in_valid (mp_in_valid),
    .mp_out_data (mp_out_data),
    .mp_out_valid(mp_out_valid)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // a*b*R^-1 mod 13, with R^-1 = 3 since 256*3 = 1 (mod 13)
  function automatic logic [DW-1:0] monpro(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return DW'((int'(a) * int'(b) * 3) % 13);
  endfunction

  // Behavioural monProduct: samples operands one cycle after launch, answers LAT cycles later
  logic          mdl_valid, mdl_busy, mdl_samp;
  logic [DW-1:0] mdl_data, ca, cb;
  logic [2:0]    mdl_cnt;
  logic          stray_hit;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl_valid <= 1'b0;
      mdl_busy  <= 1'b0;
      mdl_samp  <= 1'b0;
      mdl_data  <= '0;
      mdl_cnt   <= '0;
      ca        <= '0;
      cb        <= '0;
    end else begin
      mdl_valid <= 1'b0;
      if (mp_in_valid) begin
        mdl_busy <= 1'b1;
        mdl_samp <= 1'b1;
        mdl_cnt  <= 3'(LAT);
      end else if (mdl_busy) begin
        if (mdl_samp) begin
          ca       <= mp_opA;
          cb       <= mp_opB;
          mdl_samp <= 1'b0;
        end else begin
          check("opA_stable", mp_opA, ca);
          check("opB_stable", mp_opB, cb);
        end
        if (mdl_cnt == 3'd1) begin
          mdl_busy  <= 1'b0;
          mdl_valid <= 1'b1;
          mdl_data  <= stub ? DW'(13) : monpro(mp_opA, mp_opB);
        end
        mdl_cnt <= mdl_cnt - 3'd1;
      end
    end
  end

  // Stray completion pulse injected while the DUT is launching (not waiting)
  assign stray_hit    = stray_en && mp_in_valid;
  assign mp_out_valid = mdl_valid || stray_hit;
  assign mp_out_data  = stray_hit ? 8'hAA : mdl_data;

  // Monitor: counts launches and pops expectations on each done pulse
  int calls = 0;
  always @(negedge clk) begin
    if (rst) begin
      calls = 0;
    end else begin
      if (mp_in_valid) calls++;
      if (done) begin
        if (exp_res_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_done: got done with result %0d, expected no done", result);
        end else begin
          check("result", result, exp_res_q.pop_front());
          check("calls", calls, exp_calls_q.pop_front());
          check("busy_at_done", busy, 0);
        end
        calls = 0;
      end
    end
  end

  task automatic run(input logic [EW-1:0] e, input logic [DW-1:0] res, input int ncalls,
                     input bit do_stub, input bit do_stray, input bit poke);
    @(negedge clk);
    stub     = do_stub;
    stray_en = do_stray;
    base_m   = 8'd5;
    one_m    = 8'd9;
    mod_m    = 8'd13;
    exp      = e;
    start    = 1'b1;
    exp_res_q.push_back(res);
    exp_calls_q.push_back(ncalls);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("opM_captured", mp_opM, 13);
    // Input changes after capture must not disturb the running operation
    base_m = 8'h77;
    one_m  = 8'd3;
    mod_m  = 8'h0f;
    exp    = 8'hff;
    if (poke) begin
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 500 && exp_res_q.size() != 0; i++) @(negedge clk);
    if (exp_res_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL timeout: got no done for E=%0d, expected done within 500 cycles", e);
      exp_res_q.delete();
      exp_calls_q.delete();
    end
    @(negedge clk);
    stub     = 1'b0;
    stray_en = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    base_m = '0;
    one_m  = '0;
    mod_m  = '0;
    exp    = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {busy, done, mp_in_valid, result, mp_opA, mp_opB, mp_opM}, 0);
    rst = 1'b0;

    run(8'd5,   8'd2, 3,  1'b0, 1'b0, 1'b0);
    run(8'd12,  8'd9, 4,  1'b0, 1'b0, 1'b0);
    run(8'd0,   8'd9, 0,  1'b0, 1'b0, 1'b0);
    run(8'd1,   8'd5, 0,  1'b0, 1'b0, 1'b0);
    run(8'h80,  8'd3, 7,  1'b0, 1'b0, 1'b0);
    run(8'hff,  8'd7, 14, 1'b0, 1'b1, 1'b1);
    run(8'd5,   8'd0, 3,  1'b1, 1'b0, 1'b0);
    run(8'd12,  8'd9, 4,  1'b0, 1'b1, 1'b1);

    // Reset while a square is outstanding
    @(negedge clk);
    base_m = 8'd5;
    one_m  = 8'd9;
    mod_m  = 8'd13;
    exp    = 8'hff;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        if (mp_in_valid) seen = 1'b1;
        else @(negedge clk);
      end
      check("launch_before_reset", seen, 1);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midop_reset_outputs", {busy, done, mp_in_valid, result, mp_opA, mp_opB, mp_opM}, 0);
    @(negedge clk);
    rst = 1'b0;
    run(8'd5, 8'd2, 3, 1'b0, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
